// File: rtl/spi_matmul_slave_if.sv
// ---------------------------------------------------------------------------
// spi_matmul_slave_if
// Four-wire SPI bundle between the bridge-side master and the matmul slave.
//   spi_csb : chip select, active low        (master -> slave)
//   spi_sck : SPI clock, idles low           (master -> slave)
//   spi_sdi : MOSI, MSB first                (master -> slave)
//   spi_sdo : MISO, MSB first                (slave  -> master)
// ---------------------------------------------------------------------------
interface spi_matmul_slave_if;
  logic spi_csb;
  logic spi_sck;
  logic spi_sdi;
  logic spi_sdo;

  modport master (output spi_csb, output spi_sck, output spi_sdi, input spi_sdo);
  modport slave  (input  spi_csb, input  spi_sck, input  spi_sdi, output spi_sdo);
endinterface

// File: rtl/spi_matmul_slave.sv
// ---------------------------------------------------------------------------
// spi_matmul_slave
// SPI slave that receives two 2x2 unsigned 8-bit matrices A and B (8 bytes,
// row-major, A first), computes C = A*B with one multiply-accumulate per clk,
// and shifts C[0..3] back in the same CSB-low frame. SPI pins are async to clk
// and are oversampled through a SYNC_STAGES-deep synchronizer (2 or 3).
//
// Parameters
//   SYNC_STAGES : synchronizer depth on csb/sck/sdi (2 or 3)
//   SATURATE    : 0 = keep low 8 bits of each sum, 1 = clamp sum to 8'hFF
// Ports
//   clk          : system clock
//   resetn       : asynchronous active-low reset
//   spi          : SPI bundle (slave modport)
//   busy         : high from first received bit until frame end
//   result_valid : high while C is held, from end of compute until frame end
//   frame_err    : 1-clk pulse when CSB rises before the frame completes
// ---------------------------------------------------------------------------
module spi_matmul_slave #(
  parameter int SYNC_STAGES = 2,
  parameter bit SATURATE    = 1'b0
) (
  input  logic              clk,
  input  logic              resetn,
  spi_matmul_slave_if.slave spi,
  output logic              busy,
  output logic              result_valid,
  output logic              frame_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RX,
    S_COMPUTE,
    S_TX,
    S_DONE
  } state_t;

  // ------------------------------------------------------------------------
  // Synchronizers and edge detection. csb resets to 1 so that a reset does
  // not look like a frame start.
  // ------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] r_csb_sync, r_sck_sync, r_sdi_sync;
  logic                   r_csb_d, r_sck_d;
  logic                   w_csb, w_sck, w_sdi;
  logic                   w_csb_fall, w_csb_rise, w_sck_fall;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, as real flops do.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_csb_sync <= '1;
      r_sck_sync <= '0;
      r_sdi_sync <= '0;
      r_csb_d    <= 1'b1;
      r_sck_d    <= 1'b0;
    end else begin
      r_csb_sync <= {r_csb_sync[SYNC_STAGES-2:0], spi.spi_csb};
      r_sck_sync <= {r_sck_sync[SYNC_STAGES-2:0], spi.spi_sck};
      r_sdi_sync <= {r_sdi_sync[SYNC_STAGES-2:0], spi.spi_sdi};
      r_csb_d    <= w_csb;
      r_sck_d    <= w_sck;
    end
  end

  assign w_csb      = r_csb_sync[SYNC_STAGES-1];
  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi      = r_sdi_sync[SYNC_STAGES-1];
  assign w_csb_fall =  r_csb_d & ~w_csb;
  assign w_csb_rise = ~r_csb_d &  w_csb;
  assign w_sck_fall =  r_sck_d & ~w_sck;

  // ------------------------------------------------------------------------
  // Datapath. r_ab[0..3] = A, r_ab[4..7] = B. Compute step s (0..7) works on
  // output k = s[2:1] (row k[1], column k[0]) and inner index j = s[0]:
  //   term = A[2*row + j] * B[2*j + col]
  // Even steps start the sum, odd steps finish it and write C[k].
  // ------------------------------------------------------------------------
  state_t      r_state;
  logic [7:0]  r_ab [8];
  logic [7:0]  r_c  [4];
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [2:0]  r_byte_cnt;
  logic [2:0]  r_step;
  logic [16:0] r_acc;
  logic        r_sdo, r_busy, r_valid, r_frame_err;

  logic [1:0]  w_k;
  logic        w_j;
  logic [7:0]  w_a, w_b, w_rx_byte, w_next_c;
  logic [15:0] w_prod;
  logic [16:0] w_sum;

  assign w_k       = r_step[2:1];
  assign w_j       = r_step[0];
  assign w_a       = r_ab[{1'b0, w_k[1], w_j}];
  assign w_b       = r_ab[{1'b1, w_j, w_k[0]}];
  assign w_prod    = {8'd0, w_a} * {8'd0, w_b};
  assign w_sum     = (w_j ? r_acc : 17'd0) + {1'b0, w_prod};
  assign w_rx_byte = {r_shift[6:0], w_sdi};
  assign w_next_c  = r_c[r_byte_cnt[1:0] + 2'd1];

  function automatic logic [7:0] f_clip(input logic [16:0] sum);
    if (SATURATE && (sum > 17'd255)) return 8'hFF;
    return sum[7:0];
  endfunction

  // ------------------------------------------------------------------------
  // Frame FSM. A detected CSB rise overrides everything, including an SCK
  // fall detected in the same clk.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_byte_cnt  <= '0;
      r_step      <= '0;
      r_acc       <= '0;
      r_sdo       <= 1'b0;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      // NOTE: the operand and result arrays are cleared by reset on purpose,
      // so no value from before a reset can ever reach spi_sdo.
      for (int i = 0; i < 8; i++) r_ab[i] <= '0;
      for (int i = 0; i < 4; i++) r_c[i]  <= '0;
    end else begin
      r_frame_err <= 1'b0;
      if (w_csb_rise) begin
        r_frame_err <= (r_state == S_RX) || (r_state == S_COMPUTE) ||
                       ((r_state == S_TX) && ((r_bit_cnt != 3'd0) || (r_byte_cnt < 3'd4)));
        r_state     <= S_IDLE;
        r_busy      <= 1'b0;
        r_valid     <= 1'b0;
        r_bit_cnt   <= '0;
        r_byte_cnt  <= '0;
        r_sdo       <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_sdo <= 1'b0;
            if (w_csb_fall) begin
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
              r_state    <= S_RX;
            end
          end

          S_RX: if (w_sck_fall) begin
            r_busy  <= 1'b1;
            r_shift <= w_rx_byte;
            if (r_bit_cnt == 3'd7) begin
              r_ab[r_byte_cnt] <= w_rx_byte;
              r_bit_cnt        <= '0;
              r_byte_cnt       <= r_byte_cnt + 3'd1;
              if (r_byte_cnt == 3'd7) begin
                r_step  <= '0;
                r_state <= S_COMPUTE;
              end
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end

          S_COMPUTE: begin
            r_acc  <= w_sum;
            r_step <= r_step + 3'd1;
            if (w_j) r_c[w_k] <= f_clip(w_sum);
            // C[0] was written on step 1, so it is safe to load on the last step.
            if (r_step == 3'd7) begin
              r_shift    <= r_c[0];
              r_sdo      <= r_c[0][7];
              r_valid    <= 1'b1;
              r_bit_cnt  <= '0;
              r_byte_cnt <= '0;
              r_state    <= S_TX;
            end
          end

          S_TX: if (w_sck_fall) begin
            if (r_bit_cnt == 3'd7) begin
              r_bit_cnt <= '0;
              if (r_byte_cnt == 3'd3) begin
                // byte_cnt = 4 marks a completed read-out for the abort check.
                r_byte_cnt <= 3'd4;
                r_sdo      <= 1'b0;
                r_state    <= S_DONE;
              end else begin
                r_byte_cnt <= r_byte_cnt + 3'd1;
                r_shift    <= w_next_c;
                r_sdo      <= w_next_c[7];
              end
            end else begin
              r_shift   <= {r_shift[6:0], 1'b0};
              r_sdo     <= r_shift[6];
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end

          S_DONE: r_sdo <= 1'b0;

          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign spi.spi_sdo  = r_sdo;
  assign busy         = r_busy;
  assign result_valid = r_valid;
  assign frame_err    = r_frame_err;

endmodule

// File: tb/tb_spi_matmul_slave.sv
// ---------------------------------------------------------------------------
// tb_spi_matmul_slave
// Directed bench for spi_matmul_slave. Two instances share the master pins:
// u_dut_trunc (SYNC_STAGES=2, SATURATE=0) and u_dut_sat (SYNC_STAGES=3,
// SATURATE=1). Expected products are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_spi_matmul_slave;
  localparam int HALF = 40;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic csb    = 1'b1;
  logic sck    = 1'b0;
  logic sdi    = 1'b0;
  logic busy0, rv0, fe0, busy1, rv1, fe1;

  int n_vec    = 0;
  int n_err    = 0;
  int fe_cnt0  = 0;
  int fe_cnt1  = 0;
  int fe_base0 = 0;
  int fe_base1 = 0;

  always #5 clk = ~clk;

  spi_matmul_slave_if bus0();
  spi_matmul_slave_if bus1();

  assign bus0.spi_csb = csb;
  assign bus0.spi_sck = sck;
  assign bus0.spi_sdi = sdi;
  assign bus1.spi_csb = csb;
  assign bus1.spi_sck = sck;
  assign bus1.spi_sdi = sdi;

  spi_matmul_slave #(.SYNC_STAGES(2), .SATURATE(1'b0)) u_dut_trunc (
    .clk          (clk),
    .resetn       (resetn),
    .spi          (bus0.slave),
    .busy         (busy0),
    .result_valid (rv0),
    .frame_err    (fe0)
  );

  spi_matmul_slave #(.SYNC_STAGES(3), .SATURATE(1'b1)) u_dut_sat (
    .clk          (clk),
    .resetn       (resetn),
    .spi          (bus1.slave),
    .busy         (busy1),
    .result_valid (rv1),
    .frame_err    (fe1)
  );

  // frame_err high-cycle counters; a 1-clk pulse adds exactly one.
  always @(negedge clk) begin
    if (fe0 === 1'b1) fe_cnt0++;
    if (fe1 === 1'b1) fe_cnt1++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One SCK period: SDI changes with the rising edge, SDO sampled at the end
  // of the high phase.
  task automatic sck_bit(input logic b, output logic s0, output logic s1);
    sdi = b;
    sck = 1'b1;
    repeat (HALF - 1) @(negedge clk);
    s0 = bus0.spi_sdo;
    s1 = bus1.spi_sdo;
    @(negedge clk);
    sck = 1'b0;
    repeat (HALF) @(negedge clk);
  endtask

  // Drops CSB, clocks rx_bits of din (MSB first), and when all 64 were sent
  // waits gap clk and reads tx_bits while driving junk on SDI.
  task automatic run_frame(input string tag, input logic [63:0] din, input int rx_bits,
                           input int gap, input int tx_bits,
                           output logic [31:0] q0, output logic [31:0] q1);
    logic s0, s1;
    q0       = '0;
    q1       = '0;
    fe_base0 = fe_cnt0;
    fe_base1 = fe_cnt1;
    csb      = 1'b0;
    repeat (HALF) @(negedge clk);
    for (int i = 0; i < rx_bits; i++) sck_bit(din[63-i], s0, s1);
    if (rx_bits > 0) check({tag, "_busy"}, {30'd0, busy1, busy0}, 32'd3);
    if (rx_bits == 64) begin
      repeat (gap) @(negedge clk);
      check({tag, "_valid_pre_tx"}, {30'd0, rv1, rv0}, 32'd3);
      for (int i = 0; i < tx_bits; i++) begin
        sck_bit((i % 3) == 0, s0, s1);
        q0 = {q0[30:0], s0};
        q1 = {q1[30:0], s1};
      end
    end
  endtask

  // Raises CSB for 10 clk and checks the post-frame state.
  task automatic end_frame(input string tag, input int exp_fe);
    csb = 1'b1;
    repeat (10) @(negedge clk);
    check({tag, "_ferr_trunc"}, 32'(fe_cnt0 - fe_base0), 32'(exp_fe));
    check({tag, "_ferr_sat"},   32'(fe_cnt1 - fe_base1), 32'(exp_fe));
    check({tag, "_idle_outs"},
          {26'd0, busy1, rv1, bus1.spi_sdo, busy0, rv0, bus0.spi_sdo}, 32'd0);
  endtask

  initial begin
    logic [31:0] q0, q1;

    repeat (3) @(negedge clk);
    check("reset_outs", {24'd0, busy1, rv1, fe1, bus1.spi_sdo, busy0, rv0, fe0, bus0.spi_sdo}, 32'd0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal: A={1,2,3,4}, B={5,6,7,8}
    run_frame("nom", 64'h01020304_05060708, 64, HALF, 32, q0, q1);
    check("nom_c_trunc", q0, 32'h13162B32);
    check("nom_c_sat",   q1, 32'h13162B32);
    end_frame("nom", 0);

    // Overflow: every sum is 80000 = 0x13880
    run_frame("ovf", 64'hC8C8C8C8_C8C8C8C8, 64, HALF, 32, q0, q1);
    check("ovf_c_trunc", q0, 32'h80808080);
    check("ovf_c_sat",   q1, 32'hFFFFFFFF);
    end_frame("ovf", 0);

    // Abort after 3 bytes + 4 bits, then a clean nominal frame
    run_frame("abort", 64'h01020304_05060708, 28, 0, 0, q0, q1);
    end_frame("abort", 1);
    run_frame("post_abort", 64'h01020304_05060708, 64, HALF, 32, q0, q1);
    check("post_abort_c_trunc", q0, 32'h13162B32);
    check("post_abort_c_sat",   q1, 32'h13162B32);
    end_frame("post_abort", 0);

    // Long gap before read-out: A={9,8,7,6}, B={1,2,3,4} -> 33,50,25,38
    run_frame("gap", 64'h09080706_01020304, 64, 10420, 32, q0, q1);
    check("gap_c_trunc", q0, 32'h21321926);
    check("gap_c_sat",   q1, 32'h21321926);
    end_frame("gap", 0);

    // Reset mid TX byte 1: A={10,20,30,40}, B={2,3,4,5} -> 100,130,220,290
    run_frame("rst", 64'h0A141E28_02030405, 64, HALF, 12, q0, q1);
    check("rst_partial_trunc", q0, 32'h00000648);
    check("rst_partial_sat",   q1, 32'h00000648);
    sck = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("rst_async_outs", {24'd0, busy1, rv1, fe1, bus1.spi_sdo, busy0, rv0, fe0, bus0.spi_sdo}, 32'd0);
    @(negedge clk);
    sck = 1'b0;
    csb = 1'b1;
    repeat (5) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_release_outs", {24'd0, busy1, rv1, fe1, bus1.spi_sdo, busy0, rv0, fe0, bus0.spi_sdo}, 32'd0);

    // Back-to-back frames, CSB high for 10 clk between them
    run_frame("b2b1", 64'h0A141E28_02030405, 64, HALF, 32, q0, q1);
    check("b2b1_c_trunc", q0, 32'h6482DC22);
    check("b2b1_c_sat",   q1, 32'h6482DCFF);
    end_frame("b2b1", 0);
    run_frame("b2b2", 64'h09080706_01020304, 64, HALF, 32, q0, q1);
    check("b2b2_c_trunc", q0, 32'h21321926);
    check("b2b2_c_sat",   q1, 32'h21321926);
    end_frame("b2b2", 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
